// File: rtl/fir_frame_ctrl_if.sv
// Signal bundle between the FIRROOT frame sequencer and its host.
// The host holds the master modport; the controller uses slave.
interface fir_frame_ctrl_if #(
    parameter int DW = 8
) ();
    // Coefficient register port
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_err;

    // Frame control and sample source
    logic          start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;

    // Active coefficients and sample stream towards FIRROOT
    logic [DW-1:0] B0;
    logic [DW-1:0] B1;
    logic [DW-1:0] B2;
    logic [DW-1:0] B3;
    logic [DW-1:0] B4;
    logic [DW-1:0] B5;
    logic [DW-1:0] B6;
    logic [DW-1:0] Data_i;

    // Frame status
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          underrun;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, s_valid, s_data,
        input  cfg_err, s_ready, B0, B1, B2, B3, B4, B5, B6,
        input  Data_i, out_valid, busy, done, underrun
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, s_valid, s_data,
        output cfg_err, s_ready, B0, B1, B2, B3, B4, B5, B6,
        output Data_i, out_valid, busy, done, underrun
    );
endinterface

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer and coefficient configurator for the 7-tap FIRROOT datapath:
// shadow/active coefficient banks, one frame of samples, zero flush, output-valid tagging.
module fir_frame_ctrl #(
    parameter int NTAPS     = 7,
    parameter int DW        = 8,
    parameter int FRAME_LEN = 20,
    parameter int LAT       = 1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    fir_frame_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_COMMIT = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int SMP_W = $clog2(FRAME_LEN + 1);
    localparam int CYC_W = $clog2(NTAPS + LAT + 1);

    localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'(FRAME_LEN - 1);
    localparam logic [CYC_W-1:0] FLUSH_LAST = CYC_W'(NTAPS - 2);
    localparam logic [CYC_W-1:0] DRAIN_LAST = CYC_W'(LAT - 1);

    logic [2:0]       state_reg,    state_next;
    logic [SMP_W-1:0] smp_cnt_reg,  smp_cnt_next;
    logic [CYC_W-1:0] cyc_cnt_reg,  cyc_cnt_next;
    logic [DW-1:0]    data_reg,     data_next;
    logic             tag_reg,      tag_next;
    logic             underrun_reg, underrun_next;
    logic             cfg_err_reg;
    logic [LAT-1:0]   tag_pipe_reg;

    logic [DW-1:0]    shadow_reg [NTAPS];
    logic [DW-1:0]    active_reg [NTAPS];

    // Shadow writes are accepted in any state; the active bank only loads in COMMIT,
    // so a write landing on the COMMIT edge reaches the shadow but not this frame.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_bank
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    shadow_reg[gi] <= '0;
                    active_reg[gi] <= '0;
                end else begin
                    if (bus.cfg_we && (bus.cfg_addr == 3'(gi))) begin
                        shadow_reg[gi] <= bus.cfg_data;
                    end
                    if (state_reg == ST_COMMIT) begin
                        active_reg[gi] <= shadow_reg[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= bus.cfg_we && (32'(bus.cfg_addr) >= NTAPS);
        end
    end

    always_comb begin
        state_next    = state_reg;
        smp_cnt_next  = smp_cnt_reg;
        cyc_cnt_next  = cyc_cnt_reg;
        data_next     = '0;
        tag_next      = 1'b0;
        underrun_next = underrun_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next    = ST_COMMIT;
                    underrun_next = 1'b0;
                    smp_cnt_next  = '0;
                    cyc_cnt_next  = '0;
                end
            end
            ST_COMMIT: begin
                state_next   = ST_RUN;
                smp_cnt_next = '0;
            end
            ST_RUN: begin
                // A missing sample inserts a zero into the tap line and an untagged slot.
                if (bus.s_valid) begin
                    data_next = bus.s_data;
                    tag_next  = 1'b1;
                    if (smp_cnt_reg == SMP_LAST) begin
                        state_next   = ST_FLUSH;
                        smp_cnt_next = '0;
                        cyc_cnt_next = '0;
                    end else begin
                        smp_cnt_next = smp_cnt_reg + 1'b1;
                    end
                end else begin
                    underrun_next = 1'b1;
                end
            end
            ST_FLUSH: begin
                tag_next = 1'b1;
                if (cyc_cnt_reg == FLUSH_LAST) begin
                    state_next   = ST_DRAIN;
                    cyc_cnt_next = '0;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cyc_cnt_reg == DRAIN_LAST) begin
                    state_next   = ST_DONE;
                    cyc_cnt_next = '0;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg    <= ST_IDLE;
            smp_cnt_reg  <= '0;
            cyc_cnt_reg  <= '0;
            data_reg     <= '0;
            tag_reg      <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            smp_cnt_reg  <= smp_cnt_next;
            cyc_cnt_reg  <= cyc_cnt_next;
            data_reg     <= data_next;
            tag_reg      <= tag_next;
            underrun_reg <= underrun_next;
        end
    end

    // Tags travel alongside the filter latency so out_valid lines up with FIRout.
    generate
        if (LAT == 1) begin : g_tag_one
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    tag_pipe_reg <= '0;
                end else begin
                    tag_pipe_reg <= tag_reg;
                end
            end
        end else begin : g_tag_multi
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    tag_pipe_reg <= '0;
                end else begin
                    tag_pipe_reg <= {tag_pipe_reg[LAT-2:0], tag_reg};
                end
            end
        end
    endgenerate

    assign bus.B0        = active_reg[0];
    assign bus.B1        = active_reg[1];
    assign bus.B2        = active_reg[2];
    assign bus.B3        = active_reg[3];
    assign bus.B4        = active_reg[4];
    assign bus.B5        = active_reg[5];
    assign bus.B6        = active_reg[6];
    assign bus.Data_i    = data_reg;
    assign bus.out_valid = tag_pipe_reg[LAT-1];
    assign bus.s_ready   = (state_reg == ST_RUN);
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.underrun  = underrun_reg;
    assign bus.cfg_err   = cfg_err_reg;
endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Scoreboard bench for fir_frame_ctrl: the driver queues expected filter-input samples
// and per-frame results; a negedge monitor pops and compares as the DUT presents them.
module tb_fir_frame_ctrl;
    localparam int NTAPS     = 7;
    localparam int DW        = 8;
    localparam int FRAME_LEN = 20;
    localparam int LAT       = 1;
    localparam int NOUT      = FRAME_LEN + NTAPS - 1;

    localparam int M_CONT = 0;
    localparam int M_GAP  = 1;
    localparam int M_CWR  = 2;
    localparam int M_SRUN = 3;
    localparam int M_RAND = 4;
    localparam int M_RST  = 5;

    typedef struct packed {
        logic [NTAPS*DW-1:0] coef;
        logic                ur;
    } frame_t;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]       exp_data [$];
    frame_t              exp_frame [$];
    logic [NTAPS*DW-1:0] shadow_m = '0;
    logic [NTAPS*DW-1:0] active_m = '0;

    bit            mon_en   = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            hs_cnt   = 0;
    int            ov_cnt   = 0;
    int            frame_no = 0;
    frame_t        mon_f;

    fir_frame_ctrl_if #(.DW(DW)) bus ();

    fir_frame_ctrl #(
        .NTAPS(NTAPS), .DW(DW), .FRAME_LEN(FRAME_LEN), .LAT(LAT)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [NTAPS*DW-1:0] coefs();
        return {bus.B6, bus.B5, bus.B4, bus.B3, bus.B2, bus.B1, bus.B0};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy",      bus.busy,      0);
        chk("rst_s_ready",   bus.s_ready,   0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_done",      bus.done,      0);
        chk("rst_cfg_err",   bus.cfg_err,   0);
        chk("rst_underrun",  bus.underrun,  0);
        chk("rst_data_i",    bus.Data_i,    0);
        chk("rst_coefs",     coefs(),       0);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [DW-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        tick();
        bus.cfg_we = 1'b0;
        if (int'(a) < NTAPS) shadow_m[DW*a +: DW] = d;
        chk("cfg_err", bus.cfg_err, (int'(a) >= NTAPS));
    endtask

    task automatic mid_reset();
        #2 Rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_data.delete();
        exp_frame.delete();
        shadow_m      = '0;
        active_m      = '0;
        bus.s_valid   = 1'b0;
        bus.start     = 1'b0;
        @(negedge Clk);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        tick();
    endtask

    task automatic run_frame(input int mode);
        logic [DW-1:0] smp [$];
        frame_t        f;
        int            acc;
        int            gaps;
        int            cyc;
        int            n;
        bit            v;
        bit            gap_seen;

        for (int i = 0; i < FRAME_LEN; i++) smp.push_back(DW'($urandom_range(1, 255)));
        foreach (smp[i]) exp_data.push_back(smp[i]);
        for (int i = 0; i < NTAPS - 1; i++) exp_data.push_back('0);
        f.coef = shadow_m;
        f.ur   = 1'b0;

        chk("idle_busy", bus.busy, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("commit_busy", bus.busy, 1);
        chk("commit_underrun_clr", bus.underrun, 0);
        chk("commit_s_ready", bus.s_ready, 0);
        chk("commit_coefs_old", coefs(), active_m);

        if (mode == M_CWR) cfg_write(3'd2, 8'hAA);
        else tick();
        active_m = f.coef;
        chk("run_coefs_new", coefs(), active_m);

        acc = 0; gaps = 0; cyc = 0; gap_seen = 1'b0;
        while (acc < FRAME_LEN) begin
            case (mode)
                M_GAP:   v = !(acc == 8 && gaps < 3);
                M_RAND:  v = (cyc > 60) || ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            bus.start   = (mode == M_SRUN && acc == 5);
            bus.s_valid = v;
            bus.s_data  = v ? smp[acc] : DW'($urandom_range(1, 255));
            tick();
            bus.start = 1'b0;
            cyc++;
            if (v) begin
                chk("data_follow", bus.Data_i, smp[acc]);
                acc++;
            end else begin
                chk("gap_data_zero", bus.Data_i, 0);
                gaps++;
                gap_seen = 1'b1;
            end
            chk("underrun_state", bus.underrun, gap_seen);
            if (mode == M_RST && acc == 10) begin
                mid_reset();
                return;
            end
        end

        f.ur = gap_seen;
        exp_frame.push_back(f);
        bus.s_valid = 1'b1;
        bus.s_data  = DW'($urandom_range(1, 255));
        chk("flush_s_ready", bus.s_ready, 0);
        n = 0;
        while (n < 40 && bus.done !== 1'b1) begin
            tick();
            n++;
        end
        chk("done_seen", bus.done, 1);
        chk("flush_drain_len", n, NTAPS - 1 + LAT);
        bus.s_valid = 1'b0;
        tick();
        chk("done_once", bus.done, 0);
        chk("idle_after_done", bus.busy, 0);
    endtask

    // Monitor: out_valid marks a cycle whose filter output belongs to the previous Data_i.
    always @(negedge Clk) begin
        if (!mon_en || !Rst_n) begin
            prev_data = '0;
            hs_cnt    = 0;
            ov_cnt    = 0;
        end else begin
            if (bus.out_valid) begin
                ov_cnt++;
                if (exp_data.size() == 0) chk("out_unexpected", 1, 0);
                else chk("out_data", prev_data, exp_data.pop_front());
            end else begin
                chk("untagged_data_zero", prev_data, 0);
            end
            if (bus.s_valid && bus.s_ready) hs_cnt++;
            if (bus.done) begin
                if (exp_frame.size() == 0) begin
                    chk("frame_unexpected", 1, 0);
                end else begin
                    mon_f = exp_frame.pop_front();
                    chk("frame_handshakes", hs_cnt, FRAME_LEN);
                    chk("frame_out_valid", ov_cnt, NOUT);
                    chk("frame_underrun", bus.underrun, mon_f.ur);
                    chk("frame_coefs", coefs(), mon_f.coef);
                end
                $display("frame %0d: %0d samples accepted, %0d output-valid cycles, underrun=%0b",
                         frame_no, hs_cnt, ov_cnt, bus.underrun);
                frame_no++;
                hs_cnt = 0;
                ov_cnt = 0;
            end
            prev_data = bus.Data_i;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.start    = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;

        #4 Rst_n = 1'b0;
        #4 check_reset_outputs();
        #1 Rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
        check_reset_outputs();

        for (int a = 0; a < NTAPS; a++) cfg_write(3'(a), DW'(a + 1));
        chk("coefs_before_commit", coefs(), 0);
        cfg_write(3'd7, 8'h5A);
        tick();
        chk("cfg_err_single_pulse", bus.cfg_err, 0);

        run_frame(M_CONT);
        run_frame(M_GAP);
        run_frame(M_CWR);
        run_frame(M_SRUN);
        repeat (3) begin
            repeat (2) cfg_write(3'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
            run_frame(M_RAND);
        end
        run_frame(M_RST);
        run_frame(M_CONT);

        repeat (3) tick();
        chk("queues_drained", exp_data.size() + exp_frame.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_frame_ctrl.md
Name: fir_frame_ctrl

Overview:
- Sequencer and coefficient configurator for the FIRROOT filter datapath (7 taps, 8-bit samples and coefficients; no enable, samples Data_i every Clk).
- Holds a shadow coefficient bank written over a simple register port, and commits it atomically to the active bank driving B0..B6 at frame start.
- Streams one frame of samples from a valid/ready source into Data_i, then flushes the tap line with zeros and flags output-valid cycles aligned to FIRout/ROOTout.

Parameters:
NTAPS, 7, number of filter taps (coefficient registers B0..B(NTAPS-1))
DW, 8, sample and coefficient width
FRAME_LEN, 20, samples accepted per frame
LAT, 1, Clk cycles from Data_i change to matching FIRout/ROOTout

Ports:
Clk  in  1  clock, rising-edge
Rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  shadow coefficient write strobe
cfg_addr  in  3  coefficient index 0..NTAPS-1
cfg_data  in  DW  coefficient value
cfg_err  out  1  one-cycle pulse: write with cfg_addr >= NTAPS
start  in  1  start-frame request, honoured only in IDLE
s_valid  in  1  source sample valid
s_data  in  DW  source sample
s_ready  out  1  controller accepts sample this cycle
B0..B6  out  DW each  active coefficients to FIRROOT
Data_i  out  DW  registered sample to FIRROOT
out_valid  out  1  FIRout/ROOTout this cycle belong to the frame
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame end
underrun  out  1  sticky: gap inside RUN; cleared on start

Behaviour:
- Reset (async, Rst_n=0): state IDLE; shadow and active banks, Data_i, counters, tag pipe all 0; s_ready, out_valid, busy, done, cfg_err, underrun 0.
- Config port: cfg_we=1 and cfg_addr<NTAPS writes shadow[cfg_addr] at the edge; accepted in any state. cfg_addr>=NTAPS: no write, cfg_err=1 next cycle. Active bank never changes except in COMMIT.
- States: IDLE -> COMMIT -> RUN -> FLUSH -> DRAIN -> DONE -> IDLE.
- IDLE: s_ready=0, Data_i=0. start=1 -> COMMIT; underrun cleared. start in any other state ignored.
- COMMIT (1 cycle): active <= shadow (all taps in one edge). A cfg write in the same cycle lands in shadow only; the new value is not committed.
- RUN: s_ready=1. s_valid&s_ready: Data_i <= s_data, tag=1, sample count+1. s_valid=0: Data_i <= 0, tag=0, underrun <= 1, count unchanged. After the FRAME_LEN-th acceptance -> FLUSH (s_ready falls the following cycle).
- FLUSH (NTAPS-1 cycles): s_ready=0, Data_i <= 0, tag=1, so the filter tail emerges.
- DRAIN (LAT cycles): Data_i=0, tag=0; lets the last tags reach out_valid.
- DONE (1 cycle): done=1, busy=1; -> IDLE.
- out_valid = tag delayed by LAT cycles through a shift register (aligned with FIRout). Total out_valid cycles per frame = FRAME_LEN+NTAPS-1.
- Counters: sample counter ceil(log2(FRAME_LEN+1)) bits; flush/drain counter shared. No wrap: counter resets on entering each state.
- Reset mid-frame: immediate return to reset values; partial frame discarded; shadow contents lost.

Test Plan:
- Reset: Rst_n low at 4 ns, high at 9 ns -> all outputs 0, B0..B6=0, busy=0.
- Config+commit: write shadow 1,2,3,4,5,6,7 to addr 0..6, then start -> B0..B6 stay 0 until COMMIT edge, then read 1..7 simultaneously; busy rises the cycle after start.
- Continuous frame: 20 samples, s_valid held 1 -> exactly 20 handshakes, Data_i follows s_data one cycle later; 6 flush cycles Data_i=0; out_valid high for 26 consecutive cycles starting LAT cycles after the first accepted sample; done pulses once; underrun=0.
- Gaps: drop s_valid for 3 cycles mid-frame -> Data_i=0 those cycles, underrun=1 sticky, still exactly 20 accepted samples, out_valid low for those 3 cycles, 26 valid cycles total.
- Errors/races: cfg_addr=7 -> cfg_err pulse, shadow unchanged; cfg write during COMMIT -> not in B*, appears after the next frame's COMMIT; start during RUN -> ignored.
- Mid-frame reset: assert Rst_n=0 after sample 10 -> outputs 0 asynchronously; new start after reset runs a full 20-sample frame with B0..B6=0.
